fifo_wr_arbiter: RTL and testbench

- Round-robin write-side arbiter that shares one single-clock 8-bit FIFO (64 entries, buf_full/wr_en/buf_in interface) among NUM_REQ producers.
- Each producer uses a valid/ready stream with a last marker. The arbiter grants one producer at a time for a bounded burst and drives the FIFO write port.
- Never asserts a write while the FIFO is full. No producer starves.

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_if.sv | 23 ++
 rtl/rr_pick.sv | 41 ++++
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types, widths and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int GRANT_ID_W = 3;
   localparam int STALL_W    = 16;
   localparam int BURST_W    = 4;
   localparam int MAX_REQ    = 8;

   function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
      return (&v) ? v : v + STALL_W'(1);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer streams plus FIFO write port; master is the arbiter side.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      fifo_full;
   logic                      fifo_wr_en;
   logic [DATA_W-1:0]         fifo_din;

   modport master (
      input  req_valid, req_data, req_last, fifo_full,
      output req_ready, fifo_wr_en, fifo_din
   );

   modport slave (
      output req_valid, req_data, req_last, fifo_full,
      input  req_ready, fifo_wr_en, fifo_din
   );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index after last_ptr, wrapping.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [GRANT_ID_W-1:0] last_ptr,
   output logic                  found,
   output logic [GRANT_ID_W-1:0] index
);
   localparam int SW = GRANT_ID_W + 1;

   logic [MAX_REQ-1:0]    valid_pad;
   logic [NUM_REQ-1:0]    rot;
   logic [GRANT_ID_W-1:0] pos [NUM_REQ];

   always_comb begin
      valid_pad = '0;
      valid_pad[NUM_REQ-1:0] = req_valid;
   end

   // rot[gi] is the request gi+1 places after last_ptr
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
         logic [SW-1:0] sum;
         assign sum     = {1'b0, last_ptr} + SW'(gi + 1);
         assign pos[gi] = (sum >= SW'(NUM_REQ)) ? GRANT_ID_W'(sum - SW'(NUM_REQ))
                                                : sum[GRANT_ID_W-1:0];
         assign rot[gi] = valid_pad[pos[gi]];
      end
   endgenerate

   always_comb begin
      found = |rot;
      index = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) index = pos[k];
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arb_en,
   fifo_wr_arbiter_if.master     bus,
   output logic [GRANT_ID_W-1:0] grant_id,
   output logic                  busy,
   output logic [STALL_W-1:0]    stall_cnt
);
   arb_state_t            state_reg, state_next;
   logic [GRANT_ID_W-1:0] grant_id_reg, grant_id_next;
   logic [GRANT_ID_W-1:0] last_ptr_reg, last_ptr_next;
   logic [BURST_W-1:0]    burst_cnt_reg, burst_cnt_next;
   logic [BURST_W-1:0]    burst_inc;
   logic [STALL_W-1:0]    stall_cnt_reg, stall_cnt_next;

   logic [MAX_REQ-1:0]    valid_pad, last_pad;
   logic [DATA_W-1:0]     data_arr [MAX_REQ];
   logic                  pick_found;
   logic [GRANT_ID_W-1:0] pick_idx;
   logic                  in_grant, cur_valid, cur_last, wr_en;

   always_comb begin
      valid_pad = '0;
      last_pad  = '0;
      valid_pad[NUM_REQ-1:0] = bus.req_valid;
      last_pad[NUM_REQ-1:0]  = bus.req_last;
   end

   generate
      for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_data
         if (gi < NUM_REQ) begin : g_used
            assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
         end else begin : g_pad
            assign data_arr[gi] = '0;
         end
      end
   endgenerate

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_valid (bus.req_valid),
      .last_ptr  (last_ptr_reg),
      .found     (pick_found),
      .index     (pick_idx)
   );

   assign in_grant  = (state_reg == GRANT);
   assign cur_valid = valid_pad[grant_id_reg];
   assign cur_last  = last_pad[grant_id_reg];
   assign wr_en     = in_grant && cur_valid && !bus.fifo_full;
   assign burst_inc = burst_cnt_reg + BURST_W'(1);

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign bus.req_ready[gi] = in_grant && !bus.fifo_full &&
                                    (grant_id_reg == GRANT_ID_W'(gi));
      end
   endgenerate

   assign bus.fifo_wr_en = wr_en;
   assign bus.fifo_din   = wr_en ? data_arr[grant_id_reg] : '0;
   assign grant_id       = grant_id_reg;
   assign busy           = in_grant;
   assign stall_cnt      = stall_cnt_reg;

   always_comb begin
      state_next     = state_reg;
      grant_id_next  = grant_id_reg;
      last_ptr_next  = last_ptr_reg;
      burst_cnt_next = burst_cnt_reg;
      stall_cnt_next = stall_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (arb_en && pick_found) begin
               state_next     = GRANT;
               grant_id_next  = pick_idx;
               burst_cnt_next = '0;
            end
         end
         GRANT: begin
            // An idle producer releases even if the FIFO is full at the same time
            if (!cur_valid) begin
               state_next    = IDLE;
               last_ptr_next = grant_id_reg;
            end else if (bus.fifo_full) begin
               stall_cnt_next = sat_inc(stall_cnt_reg);
            end else begin
               burst_cnt_next = burst_inc;
               if (cur_last || (burst_inc == BURST_W'(MAX_BURST))) begin
                  state_next    = IDLE;
                  last_ptr_next = grant_id_reg;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         grant_id_reg  <= '0;
         last_ptr_reg  <= GRANT_ID_W'(NUM_REQ - 1);
         burst_cnt_reg <= '0;
         stall_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         grant_id_reg  <= grant_id_next;
         last_ptr_reg  <= last_ptr_next;
         burst_cnt_reg <= burst_cnt_next;
         stall_cnt_reg <= stall_cnt_next;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scenarios plus random traffic checked every cycle against a behavioural arbiter model.
module tb_fifo_wr_arbiter;
   localparam int NR = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic        clk;
   logic        rst;
   logic        arb_en;
   logic        full;
   logic [2:0]  grant_id;
   logic        busy;
   logic [15:0] stall_cnt;

   logic [NR-1:0] p_valid, p_last;
   logic [DW-1:0] p_data [NR];
   int            p_seq  [NR];

   fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

   assign bus.req_valid = p_valid;
   assign bus.req_last  = p_last;
   assign bus.req_data  = {p_data[3], p_data[2], p_data[1], p_data[0]};
   assign bus.fifo_full = full;

   fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk       (clk),
      .rst       (rst),
      .arb_en    (arb_en),
      .bus       (bus),
      .grant_id  (grant_id),
      .busy      (busy),
      .stall_cnt (stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Behavioural model: who owns the FIFO, how many beats so far, who was served last
   bit      m_busy;
   int      m_gid, m_last, m_beats, m_stall;
   logic [NR-1:0] acc;
   int      dut_writes;
   bit      prev_busy;
   int      order[$];

   task automatic model_reset();
      m_busy = 0; m_gid = 0; m_last = NR - 1; m_beats = 0; m_stall = 0;
   endtask

   task automatic step();
      logic [NR-1:0] e_ready;
      logic          e_wr;
      logic [DW-1:0] e_din;
      bit            done;
      int            idx;
      @(negedge clk);
      e_ready = '0; e_wr = 1'b0; e_din = '0;
      if (m_busy && !full) e_ready = NR'(1 << m_gid);
      if (m_busy && p_valid[m_gid] && !full) begin
         e_wr  = 1'b1;
         e_din = p_data[m_gid];
      end
      check("busy",      busy,           m_busy);
      check("grant_id",  grant_id,       m_gid);
      check("req_ready", bus.req_ready,  e_ready);
      check("wr_en",     bus.fifo_wr_en, e_wr);
      check("din",       bus.fifo_din,   e_din);
      check("stall_cnt", stall_cnt,      m_stall);
      acc = e_ready & p_valid;
      if (bus.fifo_wr_en === 1'b1) dut_writes++;
      if (busy === 1'b1 && !prev_busy) order.push_back(int'(grant_id));
      prev_busy = (busy === 1'b1);
      if (rst) begin
         model_reset();
      end else if (!m_busy) begin
         done = 0;
         if (arb_en) begin
            for (int k = 1; k <= NR; k++) begin
               idx = (m_last + k) % NR;
               if (!done && p_valid[idx]) begin
                  done = 1; m_gid = idx; m_beats = 0; m_busy = 1;
               end
            end
         end
      end else if (!p_valid[m_gid]) begin
         m_busy = 0; m_last = m_gid;
      end else if (full) begin
         if (m_stall < 65535) m_stall++;
      end else begin
         m_beats++;
         if (p_last[m_gid] || m_beats == MB) begin
            m_busy = 0; m_last = m_gid;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic advance(input int i);
      p_seq[i]++;
      p_data[i] = DW'(i * 64 + p_seq[i]);
   endtask

   task automatic accept_keep();
      for (int i = 0; i < NR; i++) if (acc[i]) advance(i);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      order.delete();
      prev_busy  = 0;
      dut_writes = 0;
   endtask

   task automatic all_valid();
      p_valid = '1; p_last = '0; full = 1'b0; arb_en = 1'b1;
      for (int i = 0; i < NR; i++) begin
         p_seq[i] = 0;
         p_data[i] = DW'(i * 64);
      end
   endtask

   initial begin
      int fc, b2, t;
      bit dropped;
      rst = 1'b1; arb_en = 1'b0; full = 1'b0; p_valid = '0; p_last = '0;
      for (int i = 0; i < NR; i++) begin p_data[i] = '0; p_seq[i] = 0; end
      acc = '0;

      // Single producer, three-beat packet
      reset_dut();
      arb_en = 1'b1; p_valid = 4'b0001; p_data[0] = 8'hA1;
      for (int c = 0; c < 8; c++) begin
         step();
         if (acc[0]) begin
            if (p_data[0] == 8'hA3) p_valid[0] = 1'b0;
            else begin
               p_data[0] = p_data[0] + 8'd1;
               p_last[0] = (p_data[0] == 8'hA3);
            end
         end
      end
      check("t1_writes", dut_writes, 3);
      check("t1_grant_id", grant_id, 0);

      // All producers continuously valid: round robin, full bursts, one bubble
      reset_dut();
      all_valid();
      for (int c = 0; c < 25; c++) begin
         step();
         accept_keep();
         if (c == 19) check("t2_writes_20cyc", dut_writes, 16);
      end
      check("t2_grants", order.size() >= 5, 1);
      for (int g = 0; g < 5 && g < order.size(); g++) check("t2_order", order[g], g % NR);

      // FIFO full for five cycles mid-burst of producer 2
      reset_dut();
      all_valid();
      p_valid = 4'b0100; p_data[2] = 8'h20;
      fc = 0; b2 = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (acc[2]) begin advance(2); b2++; end
         if (b2 == 2 && fc < 5) begin full = 1'b1; fc++; end
         else full = 1'b0;
      end
      check("t3_stall_cnt", stall_cnt, 5);
      check("t3_writes", dut_writes, 5);

      // Producer 1 goes idle after one beat; producer 3 wins the next grant
      reset_dut();
      all_valid();
      p_valid = 4'b0010;
      dropped = 0; t = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         accept_keep();
         if (dropped) begin
            t++;
            if (t == 1) p_valid[1] = 1'b1;
         end else if (acc[1]) begin
            p_valid[1] = 1'b0; p_valid[3] = 1'b1; dropped = 1;
         end
      end
      check("t4_grants", order.size() >= 2, 1);
      if (order.size() >= 2) begin
         check("t4_first", order[0], 1);
         check("t4_next", order[1], 3);
      end

      // arb_en dropped during a burst: burst completes, no further grants
      reset_dut();
      all_valid();
      step();
      accept_keep();
      arb_en = 1'b0;
      for (int c = 0; c < 10; c++) begin step(); accept_keep(); end
      check("t5_idle_busy", busy, 0);
      check("t5_writes", dut_writes, MB);
      arb_en = 1'b1;
      step();
      accept_keep();
      check("t5_regrant_busy", busy, 1);
      check("t5_regrant_id", grant_id, 1);

      // Reset in the middle of a burst
      reset_dut();
      all_valid();
      for (int c = 0; c < 6 && !(m_busy && m_beats == 2); c++) begin step(); accept_keep(); end
      rst = 1'b1;
      step();
      accept_keep();
      rst = 1'b0;
      check("t6_rst_busy", busy, 0);
      check("t6_rst_wr", bus.fifo_wr_en, 0);
      check("t6_rst_ready", bus.req_ready, 0);
      step();
      accept_keep();
      check("t6_first_grant", grant_id, 0);

      // Random traffic
      reset_dut();
      all_valid();
      for (int c = 0; c < 3000; c++) begin
         step();
         for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
               advance(i);
               p_valid[i] = ($urandom_range(0, 3) != 0);
               p_last[i]  = ($urandom_range(0, 4) == 0);
            end else if (!p_valid[i]) begin
               p_valid[i] = ($urandom_range(0, 2) == 0);
               p_last[i]  = ($urandom_range(0, 4) == 0);
            end
         end
         full   = ($urandom_range(0, 4) == 0);
         arb_en = ($urandom_range(0, 7) != 0);
         rst    = ($urandom_range(0, 299) == 0);
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
